msu_audio_sink: RTL

- Consumes the 16-bit sector word stream that the MSU streaming controller requests from the HPS.
- Buffers the words in a 2048-word FIFO and reports occupancy back to the controller for flow control (controller requests more while usedw < 1792).
- Drains interleaved stereo PCM (L word, then R word) at the 44.1 kHz sample rate to the audio mixer.
- Handles header skip, controller-requested word suppression, underrun and overflow.

---
 rtl/msu_audio_sink.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/msu_audio_sink.sv
`default_nettype none
// ============================================================================
//  Module      : msu_audio_sink
//  Description : Sink for the MSU sector word stream. Accepted words are
//                queued in a 2^DEPTH_LOG2-word FIFO whose occupancy is fed
//                back to the streaming controller for flow control. A
//                fractional-rate tick generator drains interleaved stereo PCM
//                (L word, then R word) to the audio mixer at SAMPLE_HZ.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   system clock
//    reset          in   synchronous, active-high
//    flush          in   synchronous FIFO clear / pair re-alignment
//    sd_ack         in   sector transfer active
//    sd_buff_wr     in   word strobe from HPS
//    sd_buff_dout   in   16-bit sector data word
//    sd_lba         in   LBA of the sector in transfer
//    ignore_in      in   drop the current word
//    audio_play     in   playback enable
//    volume         in   8-bit gain (only with MSU_AUDIO_VOLUME_EN)
//    fifo_usedw     out  FIFO occupancy, 0..2^DEPTH_LOG2
//    audio_l/_r     out  signed stereo sample
//    sample_strobe  out  one-cycle pulse when audio_l/audio_r update
//    underrun       out  sticky: sample tick while playing with < 2 words
//    overflow       out  sticky: word dropped because the FIFO was full
// ----------------------------------------------------------------------------
//  Build option
//    MSU_AUDIO_VOLUME_EN : adds the volume port and a registered scaling
//                          stage (tick-to-strobe latency 4 instead of 3).
// ============================================================================
module msu_audio_sink #(
    parameter int unsigned CLK_HZ     = 21477270,
    parameter int unsigned SAMPLE_HZ  = 44100,
    parameter int unsigned DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  sd_ack,
    input  logic                  sd_buff_wr,
    input  logic [15:0]           sd_buff_dout,
    input  logic [20:0]           sd_lba,
    input  logic                  ignore_in,
    input  logic                  audio_play,
`ifdef MSU_AUDIO_VOLUME_EN
    input  logic [7:0]            volume,
`endif
    output logic [DEPTH_LOG2:0]   fifo_usedw,
    output logic [15:0]           audio_l,
    output logic [15:0]           audio_r,
    output logic                  sample_strobe,
    output logic                  underrun,
    output logic                  overflow
);

    localparam int unsigned          c_words     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  c_depth     = (DEPTH_LOG2 + 1)'(1) << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  c_two       = (DEPTH_LOG2 + 1)'(2);
    localparam logic [31:0]          c_clk_hz    = CLK_HZ;
    localparam logic [31:0]          c_sample_hz = SAMPLE_HZ;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_L  = 3'd1,
        ST_RD_R  = 3'd2,
        ST_OUT   = 3'd3,
        ST_SCALE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic                   sd_ack_q, sd_ack_d;
    logic [7:0]             idx_q, idx_d;
    logic                   wr_pend_q, wr_pend_d;
    logic [15:0]            wr_data_q, wr_data_d;
    logic [DEPTH_LOG2:0]    wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]    rd_ptr_q, rd_ptr_d;
    logic [31:0]            acc_q, acc_d;
    logic [15:0]            l_hold_q, l_hold_d;
    logic [15:0]            audio_l_q, audio_l_d;
    logic [15:0]            audio_r_q, audio_r_d;
    logic                   underrun_q, underrun_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            rd_data_q;
    logic [15:0]            mem [c_words];
`ifdef MSU_AUDIO_VOLUME_EN
    logic [15:0]            scaled_l_q, scaled_l_d;
    logic [15:0]            scaled_r_q, scaled_r_d;
    logic signed [24:0]     prod_l, prod_r;
`endif

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                   ack_rise;
    logic [7:0]             idx_base;
    logic                   wr_strobe;
    logic                   in_header;
    logic                   accept;
    logic [DEPTH_LOG2:0]    usedw;
    logic                   fifo_full;
    logic                   wr_commit;
    logic [31:0]            acc_sum;
    logic                   tick;
    logic                   pop;
    logic                   strobe;

    assign usedw     = wr_ptr_q - rd_ptr_q;
    assign fifo_full = (usedw == c_depth);
    assign wr_commit = wr_pend_q && !fifo_full;

    // ------------------------------------------------------------------
    // Input side: word index, header skip, acceptance, tick generator
    // ------------------------------------------------------------------
    always_comb begin
        sd_ack_d  = sd_ack;
        ack_rise  = sd_ack && !sd_ack_q;
        // A strobe in the same cycle as the ack rising edge is word 0.
        idx_base  = ack_rise ? 8'd0 : idx_q;
        wr_strobe = sd_ack && sd_buff_wr;
        // Sector 0 starts with the 8-byte "MSU1" + loop-index header.
        in_header = (sd_lba == 21'd0) && (idx_base < 8'd4);
        accept    = wr_strobe && !ignore_in && !in_header;
        idx_d     = wr_strobe ? (idx_base + 8'd1) : idx_base;

        // Writes are registered first, committed to RAM one cycle later.
        wr_pend_d = accept && !flush;
        wr_data_d = accept ? sd_buff_dout : wr_data_q;

        // Exact fractional-rate tick: SAMPLE_HZ ticks per CLK_HZ cycles.
        acc_sum   = acc_q + c_sample_hz;
        tick      = (acc_sum >= c_clk_hz);
        acc_d     = tick ? (acc_sum - c_clk_hz) : acc_sum;
    end

    // ------------------------------------------------------------------
    // Read FSM and output datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        strobe     = 1'b0;
        l_hold_d   = l_hold_q;
        audio_l_d  = audio_l_q;
        audio_r_d  = audio_r_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q || (wr_pend_q && fifo_full);
`ifdef MSU_AUDIO_VOLUME_EN
        scaled_l_d = scaled_l_q;
        scaled_r_d = scaled_r_q;
        prod_l     = $signed(25'($signed(l_hold_q))) * $signed(25'({1'b0, volume}));
        prod_r     = $signed(25'($signed(rd_data_q))) * $signed(25'({1'b0, volume}));
`endif

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    if (audio_play && (usedw >= c_two)) begin
                        state_d = ST_RD_L;
                    end else begin
                        // Silence slot: emit zeros, no pop.
                        strobe    = 1'b1;
                        audio_l_d = 16'd0;
                        audio_r_d = 16'd0;
                        if (audio_play) begin
                            underrun_d = 1'b1;
                        end
                    end
                end
            end
            ST_RD_L: begin
                pop     = 1'b1;
                state_d = ST_RD_R;
            end
            ST_RD_R: begin
                l_hold_d = rd_data_q;
                pop      = 1'b1;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
`ifdef MSU_AUDIO_VOLUME_EN
                scaled_l_d = 16'(prod_l >>> 8);
                scaled_r_d = 16'(prod_r >>> 8);
                state_d    = ST_SCALE;
`else
                strobe    = 1'b1;
                audio_l_d = l_hold_q;
                audio_r_d = rd_data_q;
                state_d   = ST_IDLE;
`endif
            end
            ST_SCALE: begin
`ifdef MSU_AUDIO_VOLUME_EN
                strobe    = 1'b1;
                audio_l_d = scaled_l_q;
                audio_r_d = scaled_r_q;
`endif
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush aborts any in-flight pair and re-aligns the L/R boundary.
        if (flush) begin
            state_d    = ST_IDLE;
            pop        = 1'b0;
            strobe     = 1'b0;
            audio_l_d  = 16'd0;
            audio_r_d  = 16'd0;
            underrun_d = 1'b0;
            overflow_d = 1'b0;
        end

        wr_ptr_d = flush ? '0 : (wr_ptr_q + {{DEPTH_LOG2{1'b0}}, wr_commit});
        rd_ptr_d = flush ? '0 : (rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop});
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sd_ack_q   <= 1'b0;
            idx_q      <= 8'd0;
            wr_pend_q  <= 1'b0;
            wr_data_q  <= 16'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            acc_q      <= 32'd0;
            l_hold_q   <= 16'd0;
            audio_l_q  <= 16'd0;
            audio_r_q  <= 16'd0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
`ifdef MSU_AUDIO_VOLUME_EN
            scaled_l_q <= 16'd0;
            scaled_r_q <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            sd_ack_q   <= sd_ack_d;
            idx_q      <= idx_d;
            wr_pend_q  <= wr_pend_d;
            wr_data_q  <= wr_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            acc_q      <= acc_d;
            l_hold_q   <= l_hold_d;
            audio_l_q  <= audio_l_d;
            audio_r_q  <= audio_r_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
`ifdef MSU_AUDIO_VOLUME_EN
            scaled_l_q <= scaled_l_d;
            scaled_r_q <= scaled_r_d;
`endif
        end
    end

    // Sample RAM: one write port, one registered read port.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_q;
        end
        rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    end

    // ------------------------------------------------------------------
    // Outputs: the new sample is visible in the same cycle as the strobe
    // and held by the output registers afterwards.
    // ------------------------------------------------------------------
    assign fifo_usedw    = usedw;
    assign sample_strobe = strobe;
    assign audio_l       = strobe ? audio_l_d : audio_l_q;
    assign audio_r       = strobe ? audio_r_d : audio_r_q;
    assign underrun      = underrun_q;
    assign overflow      = overflow_q;

endmodule
`default_nettype wire
